cpu_sequencer: RTL

//  MU0 control sequencer, directly upstream of the instruction decoder.
//  - Latches each instruction word into the instruction register (IR).
//  - Drives the one-hot phase strobes FETCH/EXEC1/EXEC2 and OP[15:12] that the decoder consumes.
//  - Selects one or two execute cycles per opcode, halts on STP and counts retired instructions.

---
 rtl/cpu_sequencer_pkg.sv | 33 +++
 rtl/cpu_sequencer_ir.sv | 34 +++
 rtl/cpu_sequencer.sv | 114 +++++++++++
 3 files changed

// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the MU0 control sequencer and the instruction decoder.
// Contents:
//   OP_* constants  4-bit opcodes 0x0-0xA; codes 0xB-0xF are illegal and
//                   execute as a NOP.
//   state_e         the sequencer states.
//   needs_exec2()   1 for opcodes that use a second execute cycle.
package cpu_sequencer_pkg;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_STA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JGE = 4'h5;
  localparam logic [3:0] OP_JNE = 4'h6;
  localparam logic [3:0] OP_STP = 4'h7;
  localparam logic [3:0] OP_LDI = 4'h8;
  localparam logic [3:0] OP_LSL = 4'h9;
  localparam logic [3:0] OP_LSR = 4'hA;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC1 = 2'd1,
    S_EXEC2 = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  // Memory-operand arithmetic and loads take a second execute cycle.
  function automatic logic needs_exec2(input logic [3:0] op);
    return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/cpu_sequencer_ir.sv
// cpu_ir: the instruction register. It is a DATA_W-wide load-enable register
// with an asynchronous active-low reset. Its output is split into the opcode
// field and the operand field.
// Ports:
//   clk, rst_n  clock, async active-low reset (clears the register to 0)
//   load        capture d on the rising edge
//   d           instruction word
//   op          d[DATA_W-1:DATA_W-4] as last captured
//   operand     d[DATA_W-5:0] as last captured
module cpu_ir #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic [3:0]        op,
  output logic [DATA_W-5:0] operand
);

  logic [DATA_W-1:0] ir_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q <= '0;
    end else if (load) begin
      ir_q <= d;
    end
  end

  assign op      = ir_q[DATA_W-1:DATA_W-4];
  assign operand = ir_q[DATA_W-5:0];

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: the MU0 control sequencer. It latches instruction words into
// the IR and drives the one-hot phase strobes that the decoder consumes. Each
// opcode gets one or two execute cycles. The sequencer halts on STP and
// counts retired instructions.
// Ports:
//   CLK, RST_N   clock, async active-low reset
//   RUN          1 lets the sequencer leave FETCH; 0 pauses it in FETCH
//   MEM_Q        memory read data; holds the instruction word during FETCH
//   FETCH/EXEC1/EXEC2  registered phase strobes; all are 0 once halted
//   OP, OPERAND  IR fields for the decoder
//   IR_LOAD      1 in the cycle in which IR captures MEM_Q
//   HALTED       sticky; set when STP retires
//   INSTR_CNT    retired-instruction count; wraps modulo 2^CNT_W
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              RUN,
  input  logic [DATA_W-1:0] MEM_Q,
  output logic              FETCH,
  output logic              EXEC1,
  output logic              EXEC2,
  output logic [3:0]        OP,
  output logic [DATA_W-5:0] OPERAND,
  output logic              IR_LOAD,
  output logic              HALTED,
  output logic [CNT_W-1:0]  INSTR_CNT
);

  state_e           state_q;
  logic             fetch_q;
  logic             exec1_q;
  logic             exec2_q;
  logic             halted_q;
  logic [CNT_W-1:0] cnt_q;

  // Gating with RST_N keeps IR_LOAD low while reset is held, whatever RUN is.
  assign IR_LOAD = (state_q == S_FETCH) && RUN && RST_N;

  cpu_ir #(
    .DATA_W(DATA_W)
  ) u_ir (
    .clk    (CLK),
    .rst_n  (RST_N),
    .load   (IR_LOAD),
    .d      (MEM_Q),
    .op     (OP),
    .operand(OPERAND)
  );

  // The strobes are registered alongside the state. This keeps them
  // glitch-free for the decoder.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_FETCH;
      fetch_q  <= 1'b1;
      exec1_q  <= 1'b0;
      exec2_q  <= 1'b0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (RUN) begin
            state_q <= S_EXEC1;
            fetch_q <= 1'b0;
            exec1_q <= 1'b1;
          end
        end
        S_EXEC1: begin
          exec1_q <= 1'b0;
          if (needs_exec2(OP)) begin
            state_q <= S_EXEC2;
            exec2_q <= 1'b1;
          end else if (OP == OP_STP) begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
            cnt_q    <= cnt_q + CNT_W'(1);
          end else begin
            state_q <= S_FETCH;
            fetch_q <= 1'b1;
            cnt_q   <= cnt_q + CNT_W'(1);
          end
        end
        S_EXEC2: begin
          state_q <= S_FETCH;
          exec2_q <= 1'b0;
          fetch_q <= 1'b1;
          cnt_q   <= cnt_q + CNT_W'(1);
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q <= S_FETCH;
          fetch_q <= 1'b1;
          exec1_q <= 1'b0;
          exec2_q <= 1'b0;
        end
      endcase
    end
  end

  assign FETCH     = fetch_q;
  assign EXEC1     = exec1_q;
  assign EXEC2     = exec2_q;
  assign HALTED    = halted_q;
  assign INSTR_CNT = cnt_q;

endmodule
